mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported unified memory between instruction fetch (IF) and data access (DM) of the
//  RISC-V core. One transaction outstanding at a time. Per-requester grant/response handshakes and
//  stall outputs for the PC register and pipeline registers. Sits between the core and the memory.
// PARAMETERS
//  ADDR_W      32  address width, both requesters and memory
//  DATA_W      32  data width
//  STARVE_MAX  4   consecutive DM grants allowed while IF waits (used only with MEM_ARB_FAIR_EN)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       synchronous, active-low reset
//  if_req     in   1       fetch request, held until if_rvalid
//  if_addr    in   ADDR_W  fetch address (the PC)
//  if_gnt     out  1       1-cycle pulse: IF request accepted
//  if_rvalid  out  1       1-cycle pulse: if_rdata valid
//  if_rdata   out  DATA_W  instruction word
//  dm_req     in   1       data request, held until done
//  dm_we      in   1       1 = store, 0 = load
//  dm_addr    in   ADDR_W  data address (ALU result)
//  dm_wdata   in   DATA_W  store data (RD2)
//  dm_gnt     out  1       1-cycle pulse: DM request accepted
//  dm_rvalid  out  1       1-cycle pulse: load data valid, or store done
//  dm_rdata   out  DATA_W  load data
//  mem_req    out  1       memory request, held until mem_ready
//  mem_we     out  1       memory write enable
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_ready  in   1       memory accepts request this cycle
//  mem_rvalid in   1       memory read data valid
//  mem_rdata  in   DATA_W  memory read data
//  stall_if   out  1       IF request pending, no response this cycle
//  stall_mem  out  1       DM request pending, no response this cycle
// BEHAVIOUR
//  - FSM: IDLE, REQ_I, RSP_I, REQ_D, RSP_D. Clock and reset as decided: clk, rst sync active-low.
//  - Reset (rst=0 at edge): state IDLE; mem_req/mem_we/mem_addr/mem_wdata, gnt, rvalid, *_rdata all 0.
//  - IDLE: dm_req -> dm_gnt=1 (combinational); latch dm_addr/we/wdata; go REQ_D. Else if_req ->
//    if_gnt=1; latch if_addr; go REQ_I. Simultaneous requests: DM wins (older instruction).
//  - REQ_x: mem_req=1, latched fields stable. mem_ready=1 -> loads/fetch go RSP_x;
//    store (mem_we=1) -> dm_rvalid pulses that cycle, go IDLE.
//  - RSP_x: wait mem_rvalid; on it, x_rvalid=1 and x_rdata=mem_rdata in the same cycle (combinational);
//    go IDLE. Next grant no earlier than the following cycle.
//  - Min load/fetch latency: gnt cycle 0, mem_req cycle 1, response cycle >=2 (mem_ready=1, mem_rvalid
//    one cycle later). Min store: dm_rvalid cycle 1.
//  - *_rdata holds its last value between pulses. mem_rvalid outside RSP_x is ignored.
//  - stall_if  = if_req & ~if_rvalid; stall_mem = dm_req & ~dm_rvalid (combinational).
//  - Requester dropping req after gnt: transaction still completes, response pulse still issued.
//  - Reset mid-transaction: abort to IDLE next edge, mem_req=0, no rvalid pulse, late mem_rvalid dropped.
// CONFIGURATION
//  - MEM_ARB_FAIR_EN defined: 3-bit+ counter starve_cnt increments per DM grant while if_req=1,
//    cleared on any IF grant or when if_req=0. starve_cnt==STARVE_MAX in IDLE with both requests ->
//    IF wins. Reset clears starve_cnt.
//  - Not defined: strict DM priority; IF may starve indefinitely; no counter logic.
// TESTING
//  - Reset: rst=0 2 cycles, with if_req=1 -> all outputs 0, no gnt while rst=0.
//  - Fetch: if_req=1, if_addr=0x0000_0010, mem_ready=1, mem_rdata=0x0051_8233 one cycle later ->
//    if_gnt cycle 0, mem_addr=0x10 cycle 1, if_rvalid with 0x0051_8233 cycle 2.
//  - Collision: if_req=dm_req=1 same cycle, dm_we=1, dm_addr=0x40, dm_wdata=0xDEAD_BEEF ->
//    dm_gnt first, mem_we=1 write, dm_rvalid, then if_gnt; stall_if=1 until if_rvalid.
//  - Backpressure: mem_ready=0 for 3 cycles -> mem_req/mem_addr stable all 3 cycles, no rvalid.
//  - Reset mid-op: rst=0 in RSP_I, mem_rvalid next cycle -> no if_rvalid; IDLE.
//  - MEM_ARB_FAIR_EN, STARVE_MAX=4: dm_req and if_req held high -> 4 DM transactions, then 1 IF.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch (IF) and data access (DM).
// Define MEM_ARB_FAIR_EN to let IF win after STARVE_MAX consecutive DM grants; default is strict DM priority.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);
  // state | meaning
  // IDLE  | no transaction outstanding, grants issued combinationally
  // REQ_I | fetch presented to memory, waiting for mem_ready
  // RSP_I | fetch accepted, waiting for mem_rvalid
  // REQ_D | data access presented, waiting for mem_ready (a store completes here)
  // RSP_D | load accepted, waiting for mem_rvalid
  typedef enum logic [2:0] {IDLE, REQ_I, RSP_I, REQ_D, RSP_D} state_t;

  state_t            state;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              if_first;
  logic              pick_if;
  logic              pick_dm;
  logic              dm_load_done;

`ifdef MEM_ARB_FAIR_EN
  localparam int CNT_W = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
  logic [CNT_W-1:0] starve_cnt;

  assign if_first = (starve_cnt >= CNT_W'(STARVE_MAX));

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!if_req || pick_if) begin
      starve_cnt <= '0;
    end else if (pick_dm) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`else
  assign if_first = 1'b0;
`endif

  // DM normally wins a collision: it belongs to the older instruction in the pipeline.
  assign pick_dm = rst && (state == IDLE) && dm_req && !(if_first && if_req);
  assign pick_if = rst && (state == IDLE) && if_req && !pick_dm;
  assign if_gnt  = pick_if;
  assign dm_gnt  = pick_dm;

  assign dm_load_done = rst && (state == RSP_D) && mem_rvalid;
  assign if_rvalid    = rst && (state == RSP_I) && mem_rvalid;
  assign dm_rvalid    = dm_load_done || (rst && (state == REQ_D) && mem_we && mem_ready);
  assign if_rdata     = if_rvalid ? mem_rdata : if_rdata_q;
  assign dm_rdata     = dm_load_done ? mem_rdata : dm_rdata_q;

  assign stall_if  = rst && if_req && !if_rvalid;
  assign stall_mem = rst && dm_req && !dm_rvalid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_dm) begin
            state     <= REQ_D;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
          end else if (pick_if) begin
            state    <= REQ_I;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
          end
        end
        REQ_I: begin
          if (mem_ready) begin
            state   <= RSP_I;
            mem_req <= 1'b0;
          end
        end
        REQ_D: begin
          if (mem_ready) begin
            state   <= mem_we ? IDLE : RSP_D;
            mem_req <= 1'b0;
          end
        end
        RSP_I: begin
          if (mem_rvalid) begin
            state      <= IDLE;
            if_rdata_q <= mem_rdata;
          end
        end
        RSP_D: begin
          if (mem_rvalid) begin
            state      <= IDLE;
            dm_rdata_q <= mem_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
